// File: rtl/mode_counter.sv
// Parametrised up/down modulo counter with enable prescaler, synchronous clear/load,
// wrap or saturate at the boundary, terminal-count pulse, sticky overflow and compare match.
module mode_counter #(
    parameter int WIDTH     = 8,
    parameter int MAX_VALUE = 2**WIDTH - 1,
    parameter int PRESCALE  = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             up_down,
    input  logic             saturate,
    input  logic [WIDTH-1:0] compare_value,
    output logic [WIDTH-1:0] count,
    output logic             tc_pulse,
    output logic             overflow,
    output logic             compare_match
);

    localparam int               PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX_CNT  = WIDTH'(MAX_VALUE);
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]    prescale_cnt;
    logic [PW-1:0]    prescale_next;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] load_clamped;
    logic             tc_next;
    logic             overflow_next;
    logic             step;
    logic             at_boundary;

    always_comb begin
        step         = enable && !clear && !load && (prescale_cnt == PRE_LAST);
        at_boundary  = up_down ? (count == MAX_CNT) : (count == '0);
        load_clamped = (load_value > MAX_CNT) ? MAX_CNT : load_value;
    end

    always_comb begin
        count_next    = count;
        prescale_next = prescale_cnt;
        overflow_next = overflow;
        tc_next       = 1'b0;
        if (clear) begin
            count_next    = '0;
            prescale_next = '0;
            overflow_next = 1'b0;
        end else if (load) begin
            count_next    = load_clamped;
            prescale_next = '0;
        end else if (enable) begin
            if (step) begin
                prescale_next = '0;
                // Every step attempted at the boundary is an event, even when saturating.
                if (at_boundary) begin
                    tc_next       = 1'b1;
                    overflow_next = 1'b1;
                    if (!saturate) begin
                        count_next = up_down ? '0 : MAX_CNT;
                    end
                end else begin
                    count_next = up_down ? count + 1'b1 : count - 1'b1;
                end
            end else begin
                prescale_next = prescale_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count        <= '0;
            prescale_cnt <= '0;
            tc_pulse     <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            count        <= count_next;
            prescale_cnt <= prescale_next;
            tc_pulse     <= tc_next;
            overflow     <= overflow_next;
        end
    end

    assign compare_match = (count == compare_value);

endmodule

// File: tb/tb_mode_counter.sv
// Scoreboard bench for mode_counter: two instances (MAX 9 / prescale 2, MAX 15 / prescale 1)
// driven by shared stimulus and compared against a behavioural model each cycle.
module tb_mode_counter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_value = '0;
    logic       enable = 1'b0;
    logic       up_down = 1'b1;
    logic       saturate = 1'b0;
    logic [3:0] compare_value = '0;

    logic [3:0] count_a, count_b;
    logic       tc_a, tc_b, ovf_a, ovf_b, match_a, match_b;

    mode_counter #(.WIDTH(4), .MAX_VALUE(9), .PRESCALE(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .clear(clear), .load(load), .load_value(load_value),
        .enable(enable), .up_down(up_down), .saturate(saturate), .compare_value(compare_value),
        .count(count_a), .tc_pulse(tc_a), .overflow(ovf_a), .compare_match(match_a)
    );

    mode_counter #(.WIDTH(4), .MAX_VALUE(15), .PRESCALE(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .clear(clear), .load(load), .load_value(load_value),
        .enable(enable), .up_down(up_down), .saturate(saturate), .compare_value(compare_value),
        .count(count_b), .tc_pulse(tc_b), .overflow(ovf_b), .compare_match(match_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt0; int tc0; int ovf0; int match0;
        int cnt1; int tc1; int ovf1; int match1;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state, index 0 = dut_a, 1 = dut_b
    int maxv[2] = '{9, 15};
    int ps[2]   = '{2, 1};
    int mcnt[2], mpre[2], mtc[2], movf[2];

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mcnt[k] = 0; mpre[k] = 0; mtc[k] = 0; movf[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input bit clr, input bit ld, input int lv,
                              input bit en, input bit ud, input bit sat);
        int  mx;
        bit  hit;
        mx = maxv[k];
        mtc[k] = 0;
        if (clr) begin
            mcnt[k] = 0; mpre[k] = 0; movf[k] = 0;
        end else if (ld) begin
            mcnt[k] = (lv > mx) ? mx : lv;
            mpre[k] = 0;
        end else if (en) begin
            mpre[k]++;
            if (mpre[k] == ps[k]) begin
                mpre[k] = 0;
                hit = ud ? (mcnt[k] == mx) : (mcnt[k] == 0);
                if (hit) begin
                    mtc[k] = 1;
                    movf[k] = 1;
                end
                if (!(hit && sat))
                    mcnt[k] = ud ? (mcnt[k] + 1) % (mx + 1) : (mcnt[k] + mx) % (mx + 1);
            end
        end
    endtask

    // Drive one cycle of stimulus, predict the post-edge outputs and queue them.
    task automatic cycle(input bit clr, input bit ld, input int lv, input bit en,
                         input bit ud, input bit sat, input int cv);
        exp_t e;
        clear = clr; load = ld; load_value = 4'(lv); enable = en;
        up_down = ud; saturate = sat; compare_value = 4'(cv);
        model_step(0, clr, ld, lv, en, ud, sat);
        model_step(1, clr, ld, lv, en, ud, sat);
        e.cnt0 = mcnt[0]; e.tc0 = mtc[0]; e.ovf0 = movf[0]; e.match0 = int'(mcnt[0] == cv);
        e.cnt1 = mcnt[1]; e.tc1 = mtc[1]; e.ovf1 = movf[1]; e.match1 = int'(mcnt[1] == cv);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("count_a", int'(count_a), e.cnt0);
            chk("tc_a",    int'(tc_a),    e.tc0);
            chk("ovf_a",   int'(ovf_a),   e.ovf0);
            chk("match_a", int'(match_a), e.match0);
            chk("count_b", int'(count_b), e.cnt1);
            chk("tc_b",    int'(tc_b),    e.tc1);
            chk("ovf_b",   int'(ovf_b),   e.ovf1);
            chk("match_b", int'(match_b), e.match1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        model_reset();
        #2;
        chk("reset_count_a", int'(count_a), 0);
        chk("reset_count_b", int'(count_b), 0);
        chk("reset_tc_a", int'(tc_a), 0);
        chk("reset_ovf_a", int'(ovf_a), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Reach count 5, then assert reset between clock edges
        cycle(0, 1, 5, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 1, 0, 0);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_count_a", int'(count_a), 0);
        chk("async_rst_count_b", int'(count_b), 0);
        chk("async_rst_tc_a", int'(tc_a), 0);
        chk("async_rst_ovf_a", int'(ovf_a), 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) cycle(0, 0, 0, 1, 1, 0, 0);

        // Up wrap from 8
        cycle(0, 1, 8, 0, 1, 0, 0);
        repeat (4) cycle(0, 0, 0, 1, 1, 0, 0);
        repeat (2) cycle(0, 0, 0, 0, 1, 0, 0);

        // Down wrap, then down saturate
        cycle(0, 1, 1, 0, 0, 0, 0);
        repeat (6) cycle(0, 0, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 0, 1, 0);
        repeat (8) cycle(0, 0, 0, 1, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 1, 0);

        // Priority and clamped load
        cycle(0, 1, 7, 0, 1, 0, 0);
        cycle(1, 1, 3, 1, 1, 0, 0);
        cycle(0, 1, 15, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);

        // Prescaler with gapped enable
        cycle(1, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 1, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 1, 1, 0, 0);
        cycle(0, 0, 0, 1, 1, 0, 0);

        // Compare match while counting up
        cycle(1, 0, 0, 0, 1, 0, 3);
        repeat (12) cycle(0, 0, 0, 1, 1, 0, 3);

        // Top-of-range load and wrap on the full-range instance
        cycle(1, 0, 0, 0, 1, 0, 0);
        cycle(0, 1, 15, 0, 1, 0, 15);
        cycle(0, 0, 0, 1, 1, 0, 15);
        cycle(0, 0, 0, 0, 1, 0, 15);
        cycle(0, 0, 0, 1, 1, 1, 15);
        cycle(0, 0, 0, 1, 1, 1, 15);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(99) < 3), ($urandom_range(99) < 8), int'($urandom_range(15)),
                  ($urandom_range(99) < 70), 1'($urandom), 1'($urandom),
                  int'($urandom_range(15)));
        end

        @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
